// File: rtl/ball_launch.sv
// Ball launcher: latches the throw power and rolls a one-hot ball down the lane,
// then reports pins knocked and pulses done for the scoring stage.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   throw    throw request level, synchronous to clk
//   pow_lvl  power level 0..4 from the power-select FSM
//   ball_pos one-hot ball position (bit 0 = foul line), zero when no ball
//   busy     high while a roll or its score cycle is in progress
//   done     one-cycle pulse when the roll completes
//   pins_hit pins knocked by the last completed roll
module ball_launch #(
   parameter int LANE_LEN   = 10,
   parameter int BASE_TICKS = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                throw,
   input  logic [2:0]          pow_lvl,
   output logic [LANE_LEN-1:0] ball_pos,
   output logic                busy,
   output logic                done,
   output logic [3:0]          pins_hit
);

   // Tick counter must hold 5*BASE_TICKS-1; the longest period
   // (power 1 -> 4*BASE_TICKS) fits in the same width.
   localparam int TW = (5 * BASE_TICKS > 2) ? $clog2(5 * BASE_TICKS) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROLL  = 2'd1,
      SCORE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [LANE_LEN-1:0] ball_pos_q, ball_pos_d;
   logic [TW-1:0]       tick_q, tick_d;
   logic [2:0]          p_q, p_d;
   logic [3:0]          pins_q, pins_d;
   logic                throw_q;

   logic                throw_edge;
   logic                pow_ok;
   logic [TW-1:0]       period;
   logic                step;
   logic [3:0]          pins_tbl;

   assign throw_edge = throw & ~throw_q;
   assign pow_ok     = (pow_lvl >= 3'd1) && (pow_lvl <= 3'd4);

   // p_q is only 1..4 while rolling, so 5-p_q never wraps.
   assign period = TW'(3'd5 - p_q) * TW'(BASE_TICKS);
   assign step   = (tick_q == period - TW'(1));

   always_comb begin
      pins_tbl = 4'd10;
      case (p_q)
         3'd1:    pins_tbl = 4'd2;
         3'd2:    pins_tbl = 4'd5;
         3'd3:    pins_tbl = 4'd8;
         default: pins_tbl = 4'd10;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      ball_pos_d = ball_pos_q;
      tick_d     = tick_q;
      p_d        = p_q;
      pins_d     = pins_q;
      unique case (state_q)
         IDLE: begin
            if (throw_edge && pow_ok) begin
               p_d        = pow_lvl;
               ball_pos_d = LANE_LEN'(1);
               tick_d     = '0;
               pins_d     = '0;
               state_d    = ROLL;
            end
         end
         ROLL: begin
            if (step) begin
               tick_d = '0;
               if (ball_pos_q[LANE_LEN-1]) begin
                  ball_pos_d = '0;
                  pins_d     = pins_tbl;
                  state_d    = SCORE;
               end else begin
                  ball_pos_d = ball_pos_q << 1;
               end
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
         SCORE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // throw_q resets high so a key held through reset is not an edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         ball_pos_q <= '0;
         tick_q     <= '0;
         p_q        <= '0;
         pins_q     <= '0;
         throw_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         ball_pos_q <= ball_pos_d;
         tick_q     <= tick_d;
         p_q        <= p_d;
         pins_q     <= pins_d;
         throw_q    <= throw;
      end
   end

   assign ball_pos = ball_pos_q;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == SCORE);
   assign pins_hit = pins_q;

endmodule

// File: tb/tb_ball_launch.sv
// Directed bench for ball_launch with a cycle-age reference model.
// Small lane (4) and BASE_TICKS=2 keep the rolls short.
module tb_ball_launch;

   localparam int L  = 4;
   localparam int BT = 2;

   logic         clk;
   logic         rst_n;
   logic         throw;
   logic [2:0]   pow_lvl;
   logic [L-1:0] ball_pos;
   logic         busy;
   logic         done;
   logic [3:0]   pins_hit;

   int n_chk  = 0;
   int n_pass = 0;

   ball_launch #(.LANE_LEN(L), .BASE_TICKS(BT)) dut (
      .clk      (clk),
      .reset    (rst_n),
      .throw    (throw),
      .pow_lvl  (pow_lvl),
      .ball_pos (ball_pos),
      .busy     (busy),
      .done     (done),
      .pins_hit (pins_hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // Model: a roll is "age" cycles old; the ball is on position age/period,
   // and the cycle at age == L*period is the single score cycle.
   int m_age;
   int m_p;
   int m_pins;
   bit m_thr;

   function automatic int pins_for(input int p);
      case (p)
         1: return 2;
         2: return 5;
         3: return 8;
         default: return 10;
      endcase
   endfunction

   function automatic int per_of(input int p);
      return (5 - p) * BT;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_age  <= -1;
         m_p    <= 0;
         m_pins <= 0;
         m_thr  <= 1'b1;
      end else begin
         m_thr <= throw;
         if (m_age < 0) begin
            if (throw && !m_thr && pow_lvl >= 1 && pow_lvl <= 4) begin
               m_p    <= int'(pow_lvl);
               m_age  <= 0;
               m_pins <= 0;
            end
         end else if (m_age == L * per_of(m_p)) begin
            m_age <= -1;
         end else begin
            if (m_age + 1 == L * per_of(m_p)) m_pins <= pins_for(m_p);
            m_age <= m_age + 1;
         end
      end
   end

   function automatic int exp_ball();
      if (m_age < 0 || m_age >= L * per_of(m_p)) return 0;
      return 1 << (m_age / per_of(m_p));
   endfunction

   always @(negedge clk) begin
      check("cyc_ball", int'(ball_pos), exp_ball());
      check("cyc_busy", int'(busy), (m_age >= 0) ? 1 : 0);
      check("cyc_done", int'(done), (m_age >= 0 && m_age == L * per_of(m_p)) ? 1 : 0);
      check("cyc_pins", int'(pins_hit), m_pins);
   end

   // Caller raises throw at a negedge; this starts at the following negedge.
   // poke_c: cycle at which to toggle pow to 4 and pulse throw mid-roll.
   // press_at_done: raise throw with pow 2 on the done cycle.
   task automatic roll(input string tag, input int exp_lat, input int exp_pins,
                       input int poke_c, input bit press_at_done);
      int c;
      @(negedge clk);
      throw = 1'b0;
      check({tag, "_start_ball"}, int'(ball_pos), 1);
      check({tag, "_start_busy"}, int'(busy), 1);
      c = 0;
      while (!done && c < 300) begin
         @(negedge clk);
         c++;
         if (c == 1) check({tag, "_pins_clr"}, int'(pins_hit), 0);
         if (poke_c >= 0 && c == poke_c) begin
            pow_lvl = 3'd4;
            throw   = 1'b1;
         end
         if (poke_c >= 0 && c == poke_c + 1) throw = 1'b0;
      end
      check({tag, "_lat"}, c, exp_lat);
      check({tag, "_pins"}, int'(pins_hit), exp_pins);
      check({tag, "_end_ball"}, int'(ball_pos), 0);
      if (press_at_done) begin
         throw   = 1'b1;
         pow_lvl = 3'd2;
      end
      @(negedge clk);
      check({tag, "_idle_busy"}, int'(busy), 0);
      check({tag, "_idle_done"}, int'(done), 0);
   endtask

   initial begin
      int c;
      rst_n   = 1'b0;
      throw   = 1'b0;
      pow_lvl = 3'd0;
      repeat (3) @(negedge clk);
      check("rst_ball", int'(ball_pos), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_pins", int'(pins_hit), 0);
      rst_n = 1'b1;

      // Full-power roll: 2 cycles per position, done 8 cycles after launch.
      @(negedge clk);
      throw   = 1'b1;
      pow_lvl = 3'd4;
      roll("s1", 8, 10, -1, 1'b0);

      // Illegal power levels are ignored and pins_hit holds.
      @(negedge clk);
      throw   = 1'b1;
      pow_lvl = 3'd0;
      @(negedge clk);
      check("s3_p0_busy", int'(busy), 0);
      throw = 1'b0;
      @(negedge clk);
      throw   = 1'b1;
      pow_lvl = 3'd6;
      @(negedge clk);
      check("s3_p6_busy", int'(busy), 0);
      check("s3_p6_pins", int'(pins_hit), 10);
      throw = 1'b0;

      // Power 1: period 8, 32 cycles; mid-roll pow change and re-throw ignored.
      @(negedge clk);
      throw   = 1'b1;
      pow_lvl = 3'd1;
      roll("s2", 32, 2, 5, 1'b1);

      // Throw raised on the done cycle was seen in SCORE: no launch.
      @(negedge clk);
      check("s6_no_launch", int'(busy), 0);
      throw = 1'b0;
      @(negedge clk);
      throw   = 1'b1;
      pow_lvl = 3'd2;
      roll("s6", 24, 5, -1, 1'b0);

      // Throw held across reset release is not an edge.
      @(negedge clk);
      throw = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("s4_held_busy", int'(busy), 0);
      check("s4_held_ball", int'(ball_pos), 0);
      throw = 1'b0;
      @(negedge clk);
      throw   = 1'b1;
      pow_lvl = 3'd4;
      roll("s4", 8, 10, 3, 1'b0);

      // Asynchronous abort while the ball is on position 2.
      @(negedge clk);
      throw   = 1'b1;
      pow_lvl = 3'd4;
      @(negedge clk);
      throw = 1'b0;
      c = 0;
      while (ball_pos != 4'b0100 && c < 20) begin
         @(negedge clk);
         c++;
      end
      check("s5_reach_0100", int'(ball_pos), 4);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("s5_async_ball", int'(ball_pos), 0);
      check("s5_async_busy", int'(busy), 0);
      check("s5_async_done", int'(done), 0);
      check("s5_async_pins", int'(pins_hit), 0);
      @(negedge clk);
      check("s5_no_done", int'(done), 0);
      rst_n = 1'b1;
      @(negedge clk);
      throw   = 1'b1;
      pow_lvl = 3'd3;
      roll("s5", 16, 8, -1, 1'b0);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
